// File: rtl/lms_wb_pkg.sv
`default_nettype none
// ============================================================================
// lms_wb_pkg : shared constants and state encoding for the wb_lms sequencer
// rev 1.0
// ============================================================================
package lms_wb_pkg;

   localparam logic [31:0] c_adr_ctrl  = 32'h0000_0000;
   localparam logic [31:0] c_adr_gamma = 32'h0000_0008;
   localparam logic [31:0] c_adr_x     = 32'h0000_000C;
   localparam logic [31:0] c_adr_d     = 32'h0000_0010;

   localparam logic [15:0] c_ctrl_clear     = 16'h0008;
   localparam logic [15:0] c_ctrl_train_en  = 16'h0005;
   localparam logic [15:0] c_ctrl_train_dis = 16'h0004;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_PRE0 = 3'd1,
      ST_WR_PRE1 = 3'd2,
      ST_FETCH   = 3'd3,
      ST_WR_X    = 3'd4,
      ST_WR_D    = 3'd5,
      ST_WR_POST = 3'd6,
      ST_DONE    = 3'd7
   } seq_state_e;

   function automatic logic is_write_state(input seq_state_e s);
      return (s == ST_WR_PRE0) || (s == ST_WR_PRE1) || (s == ST_WR_X) ||
             (s == ST_WR_D)    || (s == ST_WR_POST);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_port.sv
`default_nettype none
// ============================================================================
// wb_master_port : single Wishbone classic write with ACK timeout
// rev 1.0
// ============================================================================
module wb_master_port #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [31:0] adr_i,
   input  logic [15:0] dat_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic        wb_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_o
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

   logic             active_q, active_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [31:0]      adr_q, adr_d;
   logic [15:0]      dat_q, dat_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         tmo_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         active_q <= active_d;
         tmo_q    <= tmo_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
      end
   end

   // A request is only taken while idle, so address and data stay frozen
   // for the whole strobe and every write is followed by an idle cycle.
   always_comb begin
      active_d  = active_q;
      tmo_d     = tmo_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      if (active_q) begin
         if (wb_ack_i) begin
            active_d = 1'b0;
            done_o   = 1'b1;
         end else if (tmo_q == c_tmo_last) begin
            active_d  = 1'b0;
            timeout_o = 1'b1;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else if (req_i) begin
         active_d = 1'b1;
         tmo_d    = '0;
         adr_d    = adr_i;
         dat_d    = dat_i;
      end
   end

   assign wb_cyc_o = active_q;
   assign wb_stb_o = active_q;
   assign wb_we_o  = active_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign busy_o   = active_q;

endmodule
`default_nettype wire

// File: rtl/wb_lms_seq_master.sv
`default_nettype none
// ============================================================================
// wb_lms_seq_master : sequences gamma/clear/sample/run writes into wb_lms
// rev 1.0
// ============================================================================
module wb_lms_seq_master
   import lms_wb_pkg::*;
#(
   parameter int          CNT_W     = 16,
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] ADR_CTRL  = c_adr_ctrl,
   parameter logic [31:0] ADR_GAMMA = c_adr_gamma,
   parameter logic [31:0] ADR_X     = c_adr_x,
   parameter logic [31:0] ADR_D     = c_adr_d
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [15:0]      gamma_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             s_valid_i,
   input  logic [15:0]      s_x_i,
   input  logic [15:0]      s_d_i,
   output logic             s_ready_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [31:0]      wb_adr_o,
   output logic [15:0]      wb_dat_o,
   input  logic             wb_ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] sent_o
);

   seq_state_e       state_q, state_d;
   logic             mode_q, mode_d;
   logic [15:0]      gamma_q, gamma_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic [15:0]      x_q, x_d;
   logic [15:0]      d_q, d_d;
   logic             err_q, err_d;

   logic             wr_req, wr_busy, wr_done, wr_tmo;
   logic [31:0]      wr_adr;
   logic [15:0]      wr_dat;
   logic [CNT_W-1:0] sent_inc;
   logic             last_smp;

   assign sent_inc = sent_q + CNT_W'(1);
   assign last_smp = (sent_inc == count_q);

   wb_master_port #(
      .TIMEOUT (TIMEOUT)
   ) u_port (
      .clk       (clk),
      .rst       (rst),
      .req_i     (wr_req),
      .adr_i     (wr_adr),
      .dat_i     (wr_dat),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_i  (wb_ack_i),
      .busy_o    (wr_busy),
      .done_o    (wr_done),
      .timeout_o (wr_tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         gamma_q <= '0;
         count_q <= '0;
         sent_q  <= '0;
         x_q     <= '0;
         d_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         gamma_q <= gamma_d;
         count_q <= count_d;
         sent_q  <= sent_d;
         x_q     <= x_d;
         d_q     <= d_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      gamma_d   = gamma_q;
      count_d   = count_q;
      sent_d    = sent_q;
      x_d       = x_q;
      d_d       = d_q;
      err_d     = err_q;
      wr_adr    = '0;
      wr_dat    = '0;
      s_ready_o = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start_i) begin
               mode_d  = mode_i;
               gamma_d = gamma_i;
               count_d = count_i;
               sent_d  = '0;
               err_d   = 1'b0;
               state_d = ST_WR_PRE0;
            end
         end
         ST_WR_PRE0: begin
            wr_adr = mode_q ? ADR_GAMMA : ADR_CTRL;
            wr_dat = mode_q ? gamma_q : c_ctrl_train_dis;
            if (wr_done) state_d = ST_WR_PRE1;
         end
         ST_WR_PRE1: begin
            wr_adr = ADR_CTRL;
            wr_dat = c_ctrl_clear;
            if (wr_done) begin
               if (count_q == '0) state_d = mode_q ? ST_WR_POST : ST_DONE;
               else               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            s_ready_o = 1'b1;
            if (s_valid_i) begin
               x_d     = s_x_i;
               d_d     = s_d_i;
               state_d = ST_WR_X;
            end
         end
         ST_WR_X: begin
            wr_adr = ADR_X;
            wr_dat = x_q;
            if (wr_done) begin
               if (mode_q) begin
                  state_d = ST_WR_D;
               end else begin
                  sent_d  = sent_inc;
                  state_d = last_smp ? ST_DONE : ST_FETCH;
               end
            end
         end
         ST_WR_D: begin
            wr_adr = ADR_D;
            wr_dat = d_q;
            if (wr_done) begin
               sent_d  = sent_inc;
               state_d = last_smp ? ST_WR_POST : ST_FETCH;
            end
         end
         ST_WR_POST: begin
            wr_adr = ADR_CTRL;
            wr_dat = c_ctrl_train_en;
            if (wr_done) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // An unanswered write aborts the whole sequence.
      if (wr_tmo) begin
         err_d   = 1'b1;
         state_d = ST_DONE;
      end
   end

   assign wr_req = is_write_state(state_q) && !wr_busy;
   assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done_o = (state_q == ST_DONE);
   assign err_o  = err_q;
   assign sent_o = sent_q;

endmodule
`default_nettype wire
